// File: rtl/wormy_input_ctrl.sv
// Purpose: synchronize and debounce four direction buttons, filter and queue turns, and issue one turn per game tick.
// Latency: a press reaches the queue DebounceCycles+2 edges after the raw button rises; the command follows the tick edge by one cycle.
// Backpressure: none upstream; when the 2-entry queue is full (and not popping), new presses are discarded with a dropped pulse.
module wormy_input_ctrl #(
    parameter int DebounceCycles = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       tick,
    output logic       button_pushed,
    output logic [1:0] button_state,
    output logic [1:0] queue_count,
    output logic       dropped
);

    typedef logic [1:0] dir_t;

    localparam logic [7:0] CntLast = 8'(DebounceCycles - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;

    // Input conditioning state
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;
    logic [3:0] deb_lvl;
    logic [7:0] deb_cnt [4];

    // Per-bit debounce results for the current edge
    logic [3:0] deb_flip;
    logic [3:0] press_vld;

    // Arbitration results
    logic       cand_vld;
    dir_t       cand_dat;
    logic [3:0] cand_onehot;
    logic       lost_any;

    // Queue storage: q_head is the oldest entry, q_tail_slot the second
    dir_t       q_head;
    dir_t       q_tail_slot;
    logic [1:0] q_cnt;
    dir_t       q_tail;

    // Issue side
    logic [0:0] state;
    dir_t       last_dir;
    logic       pop_vld;

    // Filter results
    dir_t       ref_dir;
    logic       is_rev;
    logic       is_same;
    logic       q_blocked;
    logic       push_vld;
    logic       drop_nxt;

    // Two-flop synchronizer on every button bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 4'b0000;
            sync_q2 <= 4'b0000;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Detect the edge on which a bit's debounced level is about to flip, and which flips are presses
    always_comb begin
        deb_flip  = 4'b0000;
        press_vld = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            deb_flip[i]  = (sync_q2[i] != deb_lvl[i]) && (deb_cnt[i] == CntLast);
            press_vld[i] = deb_flip[i] && sync_q2[i];
        end
    end

    // Debounce counters: clear on agreement, count on disagreement, flip the level after enough samples
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= 8'd0;
                end else if (deb_flip[i]) begin
                    deb_lvl[i] <= sync_q2[i];
                    deb_cnt[i] <= 8'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Fixed-priority arbitration: Up, Right, Down, Left
    always_comb begin
        cand_vld    = 1'b0;
        cand_dat    = 2'b00;
        cand_onehot = 4'b0000;
        if (press_vld[0]) begin
            cand_vld    = 1'b1;
            cand_dat    = 2'b00;
            cand_onehot = 4'b0001;
        end else if (press_vld[1]) begin
            cand_vld    = 1'b1;
            cand_dat    = 2'b01;
            cand_onehot = 4'b0010;
        end else if (press_vld[2]) begin
            cand_vld    = 1'b1;
            cand_dat    = 2'b10;
            cand_onehot = 4'b0100;
        end else if (press_vld[3]) begin
            cand_vld    = 1'b1;
            cand_dat    = 2'b11;
            cand_onehot = 4'b1000;
        end
        lost_any = |(press_vld & ~cand_onehot);
    end

    // Compare the candidate against the newest committed heading (pre-pop queue contents)
    always_comb begin
        q_tail    = (q_cnt == 2'd2) ? q_tail_slot : q_head;
        ref_dir   = (q_cnt != 2'd0) ? q_tail : last_dir;
        pop_vld   = (state == StIdle) && tick && (q_cnt != 2'd0);
        is_rev    = (cand_dat == (ref_dir ^ 2'b10));
        is_same   = (cand_dat == ref_dir);
        q_blocked = (q_cnt == 2'd2) && !pop_vld;
        push_vld  = cand_vld && !is_rev && !is_same && !q_blocked;
        drop_nxt  = lost_any
                  || (cand_vld && is_rev)
                  || (cand_vld && !is_rev && !is_same && q_blocked);
    end

    // Two-entry turn queue; a simultaneous pop and push are both honoured
    always_ff @(posedge clk) begin
        if (rst) begin
            q_head      <= 2'b00;
            q_tail_slot <= 2'b00;
            q_cnt       <= 2'd0;
        end else begin
            case ({pop_vld, push_vld})
                2'b10: begin
                    q_head <= q_tail_slot;
                    q_cnt  <= q_cnt - 2'd1;
                end
                2'b01: begin
                    if (q_cnt == 2'd0) begin
                        q_head <= cand_dat;
                    end else begin
                        q_tail_slot <= cand_dat;
                    end
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b11: begin
                    if (q_cnt == 2'd1) begin
                        q_head <= cand_dat;
                    end else begin
                        q_head      <= q_tail_slot;
                        q_tail_slot <= cand_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Issue FSM: one command cycle per tick, always one cycle after the core's update
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            button_pushed <= 1'b0;
            button_state  <= 2'b00;
            last_dir      <= 2'b00;
        end else begin
            case (state)
                StIdle: begin
                    if (pop_vld) begin
                        state         <= StIssue;
                        button_pushed <= 1'b1;
                        button_state  <= q_head;
                        last_dir      <= q_head;
                    end
                end
                default: begin
                    state         <= StIdle;
                    button_pushed <= 1'b0;
                end
            endcase
        end
    end

    // Registered single-cycle discard indication
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else begin
            dropped <= drop_nxt;
        end
    end

    assign queue_count = q_cnt;

endmodule

// File: tb/tb_wormy_input_ctrl.sv
// Directed bench for wormy_input_ctrl with DebounceCycles=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Expected values are hand-derived from the edge numbering of the timing description.
module tb_wormy_input_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       tick;
    logic       button_pushed;
    logic [1:0] button_state;
    logic [1:0] queue_count;
    logic       dropped;

    int checks;
    int failures;

    localparam logic [3:0] BtnUp    = 4'b0001;
    localparam logic [3:0] BtnRight = 4'b0010;
    localparam logic [3:0] BtnDown  = 4'b0100;
    localparam logic [3:0] BtnLeft  = 4'b1000;

    wormy_input_ctrl #(.DebounceCycles(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .tick          (tick),
        .button_pushed (button_pushed),
        .button_state  (button_state),
        .queue_count   (queue_count),
        .dropped       (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 4'b0000;
        tick    = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Raise the buttons and stop right after the debounced flip edge (edge 6 for DebounceCycles=4)
    task automatic hold(input logic [3:0] b);
        btn_raw = b;
        step(6);
    endtask

    task automatic release_btn();
        btn_raw = 4'b0000;
        step(8);
    endtask

    // Pulse tick for exactly one sampling edge
    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        btn_raw  = 4'b0000;
        tick     = 1'b0;
        step(3);

        // Reset state
        chk("rst_pushed", button_pushed, 1'b0);
        chk("rst_state", button_state, 2'b00);
        chk("rst_count", queue_count, 2'd0);
        chk("rst_dropped", dropped, 1'b0);

        // Single press: Right
        rst     = 1'b0;
        btn_raw = BtnRight;
        step(5);
        chk("single_count_e5", queue_count, 2'd0);
        step(1);
        chk("single_count_e6", queue_count, 2'd1);
        chk("single_dropped_e6", dropped, 1'b0);
        step(3);
        pulse_tick();
        chk("single_pushed_e10", button_pushed, 1'b1);
        chk("single_state_e10", button_state, 2'b01);
        chk("single_count_e10", queue_count, 2'd0);
        step(1);
        chk("single_pushed_e11", button_pushed, 1'b0);
        release_btn();

        // Bounce: three synced high samples never flip the level
        btn_raw = BtnUp;
        step(3);
        btn_raw = 4'b0000;
        step(3);
        chk("bounce_dropped", dropped, 1'b0);
        step(5);
        chk("bounce_count", queue_count, 2'd0);
        btn_raw = BtnUp;
        step(5);
        chk("bounce_hold_e5", queue_count, 2'd0);
        step(1);
        chk("bounce_hold_e6", queue_count, 2'd1);
        chk("bounce_hold_dropped", dropped, 1'b0);
        pulse_tick();
        chk("bounce_issue_pushed", button_pushed, 1'b1);
        chk("bounce_issue_state", button_state, 2'b00);
        release_btn();

        // Reversal filtering
        do_reset();
        hold(BtnDown);
        chk("rev_down_dropped", dropped, 1'b1);
        chk("rev_down_count", queue_count, 2'd0);
        step(1);
        chk("rev_down_pulse_end", dropped, 1'b0);
        release_btn();
        hold(BtnRight);
        chk("rev_right_count", queue_count, 2'd1);
        chk("rev_right_dropped", dropped, 1'b0);
        release_btn();
        hold(BtnLeft);
        chk("rev_left_dropped", dropped, 1'b1);
        chk("rev_left_count", queue_count, 2'd1);
        release_btn();

        // Priority and overflow
        do_reset();
        hold(BtnUp | BtnRight);
        chk("prio_dropped", dropped, 1'b1);
        chk("prio_count", queue_count, 2'd0);
        release_btn();
        hold(BtnRight);
        chk("ovf_right_count", queue_count, 2'd1);
        release_btn();
        hold(BtnDown);
        chk("ovf_down_count", queue_count, 2'd2);
        chk("ovf_down_dropped", dropped, 1'b0);
        release_btn();
        hold(BtnLeft);
        chk("ovf_left_dropped", dropped, 1'b1);
        chk("ovf_left_count", queue_count, 2'd2);
        release_btn();
        pulse_tick();
        chk("ovf_issue1_pushed", button_pushed, 1'b1);
        chk("ovf_issue1_state", button_state, 2'b01);
        chk("ovf_issue1_count", queue_count, 2'd1);
        step(1);
        chk("ovf_issue1_end", button_pushed, 1'b0);
        step(1);
        pulse_tick();
        chk("ovf_issue2_pushed", button_pushed, 1'b1);
        chk("ovf_issue2_state", button_state, 2'b10);
        chk("ovf_issue2_count", queue_count, 2'd0);
        step(2);

        // Pop and push on the same edge
        do_reset();
        hold(BtnRight);
        chk("pp_setup_count", queue_count, 2'd1);
        release_btn();
        btn_raw = BtnDown;
        step(5);
        pulse_tick();
        chk("pp_pushed", button_pushed, 1'b1);
        chk("pp_state", button_state, 2'b01);
        chk("pp_count", queue_count, 2'd1);
        chk("pp_dropped", dropped, 1'b0);
        step(1);
        pulse_tick();
        chk("pp_issue2_state", button_state, 2'b10);
        chk("pp_issue2_count", queue_count, 2'd0);
        release_btn();

        // Reset in the middle of operation, on the tick edge, with Left held through it
        do_reset();
        hold(BtnRight);
        release_btn();
        hold(BtnDown);
        chk("mid_setup_count", queue_count, 2'd2);
        release_btn();
        btn_raw = BtnLeft;
        rst     = 1'b1;
        tick    = 1'b1;
        step(1);
        rst  = 1'b0;
        tick = 1'b0;
        chk("mid_pushed", button_pushed, 1'b0);
        chk("mid_state", button_state, 2'b00);
        chk("mid_count", queue_count, 2'd0);
        chk("mid_dropped", dropped, 1'b0);
        step(1);
        chk("mid_no_issue", button_pushed, 1'b0);
        step(4);
        chk("mid_rereg_e5", queue_count, 2'd0);
        step(1);
        chk("mid_rereg_e6", queue_count, 2'd1);
        chk("mid_rereg_dropped", dropped, 1'b0);
        release_btn();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wormy_input_ctrl.md
# wormy_input_ctrl

Input controller and turn scheduler for the wormy game core. It synchronizes and debounces four raw direction buttons and arbitrates simultaneous presses. It rejects 180° reversals and queues up to two turns, then releases exactly one turn per game update tick. The single-cycle `button_pushed`/`button_state` command always lands on the cycle after the core's update pulse, never on it.

## Interface
- `DebounceCycles`, default 16: consecutive synchronized samples a button must differ from its debounced level before that level flips; range 2..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  4  asynchronous buttons, active-high: bit0 Up, bit1 Right, bit2 Down, bit3 Left.
- `tick`  in  1  one-cycle game update pulse; the same signal as the core's internal update.
- `button_pushed`  out  1  one-cycle turn command to the core.
- `button_state`  out  2  direction of the command: 00 Up, 01 Right, 10 Down, 11 Left.
- `queue_count`  out  2  entries currently queued, 0..2.
- `dropped`  out  1  one-cycle pulse when a press is discarded (lost arbitration, reversal, or queue full).

## Operation
- **Synchronizer:** two flops per bit.
- **Debouncer:** an 8-bit counter per bit.
  - Counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments.
  - On the edge where a mismatch is seen with counter == DebounceCycles-1, the debounced level flips and the counter clears.
- **Press event:** a debounced 0→1 flip of a bit, evaluated on that same edge. A 1→0 flip produces nothing.
- **Arbitration:** when several press events occur on one edge, the lowest bit index wins (Up > Right > Down > Left). Each loser pulses `dropped` next cycle; `dropped` is a single pulse even if several are lost.
- **Reference direction:** the last queued entry if the queue is non-empty, else `last_dir`, the last issued direction. Reset value of `last_dir` is 00 (Up), matching the core's reset heading.
- **Filter on the winning candidate `c`:**
  - `c == ref ^ 2'b10` (reversal): discard and pulse `dropped`.
  - `c == ref`: discard silently, since it would be a no-op.
  - Otherwise push if not full. If full, discard and pulse `dropped`.
- **Queue:** 2-entry FIFO.
  - Pop and push on the same edge are both performed.
  - When the queue is full and a pop occurs, the push is accepted and the count stays 2.
  - Reference selection for a simultaneous push uses pre-pop contents. This is consistent because the popped entry becomes `last_dir`.
- **Issue FSM:**
  - States: IDLE, ISSUE.
  - IDLE→ISSUE on an edge where `tick`=1 and `queue_count`≠0. On that edge, pop the head into `button_state`, set `button_pushed`=1, and set `last_dir` to the head.
  - ISSUE→IDLE unconditionally on the next edge, with `button_pushed`=0.
  - `tick` with an empty queue: no command, stay IDLE.
  - `tick` arriving while in ISSUE is impossible in normal use (core period ≥ 2). If it occurs, it is ignored.
- **Reset:** all of the following clear.
  - `button_pushed`=0, `button_state`=00, `queue_count`=0, `dropped`=0.
  - Synchronizer, debounced levels, counters, queue, FSM=IDLE, `last_dir`=00.
  - A button held through reset is seen as a fresh press after release of `rst`.

## Timing
- Define edge 1 as the first edge sampling `btn_raw` high (stable thereafter).
  - Synced value is high after edge 2.
  - Debounced flip, arbitration and queue write occur at edge DebounceCycles+2.
  - `queue_count` and `dropped` are visible after that edge.
- A glitch shorter than DebounceCycles synced samples never flips the level. The counter restarts from 0 on any matching sample.
- `tick` at edge T with a non-empty queue: `button_pushed`=1 during cycle T..T+1, i.e. sampled by the core at edge T+1, one cycle after its update.
- `queue_count` decrements after edge T.
- All outputs are registered; there are no combinational input→output paths.
- Reset mid-operation: `rst` high at edge R clears everything after R. A pending ISSUE is cancelled and no command is emitted.

## Test plan
- **Single press:** DebounceCycles=4; `btn_raw`=0010 (Right) held.
  - `queue_count`=1 after edge 6.
  - `tick` at edge 10 gives `button_pushed`=1 with `button_state`=01 after edge 10, low after edge 11.
  - `queue_count`=0 after edge 10.
- **Bounce:** pulse bit0 high for 3 synced cycles, then low, DebounceCycles=4.
  - No queue change, `dropped`=0.
  - Then hold bit0 high: press is accepted 4 samples later.
- **Reversal:** after reset (`last_dir`=00), press Down (`btn_raw`=0100).
  - `dropped` pulses, `queue_count` stays 0.
  - Press Right, then Left: Right is queued, Left is dropped, since Left reverses the queued Right.
- **Overflow and priority:**
  - Press Up+Right simultaneously (0011): Up is silently discarded because it equals `ref`=Up, so Right does not win. Right then Down in sequence gives `queue_count`=2.
  - A third press, Left: `dropped` pulses, `queue_count` stays 2.
  - Two ticks issue 01 then 10 in order.
- **Pop+push same edge:** queue = [Right], Down's debounced flip coincides with `tick`.
  - Right is issued, Down is accepted, `queue_count`=1.
- **Reset mid-operation:** queue = 2 entries, `rst` asserted on the `tick` edge.
  - No `button_pushed`; all outputs 0 next cycle.
  - A held button re-registers DebounceCycles+2 edges after `rst` falls.
